// File: rtl/ibex_mult_pext_seq.sv
// ibex_mult_pext_seq: iterative packed-SIMD multiply/accumulate engine.
// One (MUL_W+1)x(MUL_W+1) signed multiplier is reused across cycles.
// Lane mode: per-lane dot product with optional cross, subtract and saturate.
// Full mode: XLEN x XLEN product with high/low word select.
// An optional rd accumulate step runs before the result is presented.
module ibex_mult_pext_seq #(
  parameter int XLEN  = 32,
  parameter int MUL_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            full_mode_i,
  input  logic            signed_a_i,
  input  logic            signed_b_i,
  input  logic            crossed_i,
  input  logic            sub_i,
  input  logic            sat_i,
  input  logic            hi_i,
  input  logic            accum_i,
  input  logic            acc_sub_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [XLEN-1:0] rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            sat_o
);

  localparam int NL = XLEN / MUL_W;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;
  localparam int AW = 2 * XLEN + 2;
  localparam int PW = 2 * MUL_W + 2;

  if (!((NL == 1 || NL == 2 || NL == 4) && (NL * MUL_W == XLEN))) begin : g_bad_cfg
    $error("ibex_mult_pext_seq: XLEN/MUL_W must be exactly 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, ACC = 2'd2, DONE = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     i_q, i_d, j_q, j_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic              full_q, full_d, sa_q, sa_d, sb_q, sb_d, cross_q, cross_d;
  logic              sub_q, sub_d, satm_q, satm_d, hi_q, hi_d;
  logic              accum_q, accum_d, asub_q, asub_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              sat_q, sat_d, valid_q, valid_d, ready_q, ready_d;

  logic [MUL_W-1:0]  a_lane_s [NL];
  logic [MUL_W-1:0]  b_lane_s [NL];
  logic [LW-1:0]     bi_s;
  logic [MUL_W-1:0]  a_sel_s, b_sel_s;
  logic              a_ext_s, b_ext_s, last_s;
  logic signed [PW-1:0] prod_s;
  logic [AW-1:0]     prod_ext_s, term_s, rd_ext_s, acc_upd_s;
  logic [XLEN-1:0]   word_s, new_word_s;
  logic [31:0]       shamt_s;

  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign a_lane_s[k] = a_q[k*MUL_W +: MUL_W];
    assign b_lane_s[k] = b_q[k*MUL_W +: MUL_W];
  end

  // Turn the wide sum into the visible result word and saturation flag.
  function automatic logic [XLEN:0] finalize(input logic [AW-1:0] acc, input logic full,
                                             input logic hi, input logic sat_en);
    logic [AW-XLEN:0] top;
    logic             ovf;
    top = acc[AW-1:XLEN-1];
    ovf = ~((&top) | ~(|top));
    if (full) begin
      return hi ? {1'b0, acc[2*XLEN-1:XLEN]} : {1'b0, acc[XLEN-1:0]};
    end else if (sat_en && ovf) begin
      return acc[AW-1] ? {1'b1, 1'b1, {(XLEN-1){1'b0}}} : {1'b1, 1'b0, {(XLEN-1){1'b1}}};
    end else begin
      return {1'b0, acc[XLEN-1:0]};
    end
  endfunction

  // Select this cycle's chunk pair and form the shifted/negated partial product.
  always_comb begin
    if (full_q) begin
      bi_s = j_q;
    end else if (cross_q && (NL > 1)) begin
      bi_s = i_q ^ LW'(1);
    end else begin
      bi_s = i_q;
    end
    a_sel_s    = a_lane_s[i_q];
    b_sel_s    = b_lane_s[bi_s];
    // In full mode only the top chunk carries the operand sign.
    a_ext_s    = sa_q & a_sel_s[MUL_W-1] & (!full_q | (i_q == LW'(NL - 1)));
    b_ext_s    = sb_q & b_sel_s[MUL_W-1] & (!full_q | (bi_s == LW'(NL - 1)));
    prod_s     = $signed({a_ext_s, a_sel_s}) * $signed({b_ext_s, b_sel_s});
    prod_ext_s = {{(AW-PW){prod_s[PW-1]}}, prod_s};
    shamt_s    = (32'(i_q) + 32'(j_q)) * MUL_W;
    if (full_q) begin
      term_s = prod_ext_s << shamt_s;
      last_s = (i_q == LW'(NL - 1)) && (j_q == LW'(NL - 1));
    end else begin
      term_s = (sub_q && !i_q[0]) ? -prod_ext_s : prod_ext_s;
      last_s = (i_q == LW'(NL - 1));
    end
  end

  // Accumulate step: lane mode works on the wide sum, full mode wraps the selected word.
  always_comb begin
    rd_ext_s   = {{(AW-XLEN){rd_q[XLEN-1]}}, rd_q};
    word_s     = hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    new_word_s = asub_q ? (rd_q - word_s) : (word_s + rd_q);
    acc_upd_s  = acc_q;
    if (!full_q) begin
      acc_upd_s = asub_q ? (rd_ext_s - acc_q) : (acc_q + rd_ext_s);
    end else if (hi_q) begin
      acc_upd_s[2*XLEN-1:XLEN] = new_word_s;
    end else begin
      acc_upd_s[XLEN-1:0] = new_word_s;
    end
  end

  // Next-state logic, operand capture, accumulator update and output registers.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    full_d  = full_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cross_d = cross_q;
    sub_d   = sub_q;
    satm_d  = satm_q;
    hi_d    = hi_q;
    accum_d = accum_q;
    asub_d  = asub_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          full_d  = full_mode_i;
          sa_d    = signed_a_i;
          sb_d    = signed_b_i;
          cross_d = crossed_i;
          sub_d   = sub_i;
          satm_d  = sat_i;
          hi_d    = hi_i;
          accum_d = accum_i;
          asub_d  = acc_sub_i;
          a_d     = op_a_i;
          b_d     = op_b_i;
          rd_d    = rd_i;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + term_s;
          if (last_s) begin
            i_d     = '0;
            j_d     = '0;
            state_d = accum_q ? ACC : DONE;
          end else if (full_q && (j_q != LW'(NL - 1))) begin
            j_d = j_q + LW'(1);
          end else begin
            j_d = '0;
            i_d = i_q + LW'(1);
          end
        end
      end
      ACC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d   = acc_upd_s;
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush_i || ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if ((state_d == DONE) && (state_q != DONE)) begin
      {sat_d, result_d} = finalize(acc_d, full_q, hi_q, satm_q);
    end else begin
      sat_d    = sat_q;
      result_d = result_q;
    end
    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  // State, datapath and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      full_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cross_q  <= 1'b0;
      sub_q    <= 1'b0;
      satm_q   <= 1'b0;
      hi_q     <= 1'b0;
      accum_q  <= 1'b0;
      asub_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      full_q   <= full_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cross_q  <= cross_d;
      sub_q    <= sub_d;
      satm_q   <= satm_d;
      hi_q     <= hi_d;
      accum_q  <= accum_d;
      asub_q   <= asub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Self-checking bench for ibex_mult_pext_seq (XLEN=32, MUL_W=16).
// Flag vectors are packed as {full, sa, sb, cr, sub, sat, hi, acc, asub}.
module tb_ibex_mult_pext_seq;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, full_mode_i, signed_a_i, signed_b_i;
  logic        crossed_i, sub_i, sat_i, hi_i, accum_i, acc_sub_i, flush_i;
  logic        valid_o, ready_i, sat_o;
  logic [31:0] op_a_i, op_b_i, rd_i, result_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ibex_mult_pext_seq dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .full_mode_i(full_mode_i), .signed_a_i(signed_a_i), .signed_b_i(signed_b_i),
    .crossed_i(crossed_i), .sub_i(sub_i), .sat_i(sat_i), .hi_i(hi_i),
    .accum_i(accum_i), .acc_sub_i(acc_sub_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .rd_i(rd_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .sat_o(sat_o)
  );

  // Reference: full mode as a 64-bit product, lane mode as a signed integer dot product.
  function automatic logic [32:0] ref_model(input logic [8:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] rd);
    logic full, sa, sb, cr, sub, sat, hi, acc, asub;
    logic [63:0] pa, pb, prod;
    logic [31:0] w;
    logic [15:0] la, lb;
    longint sum, p, x, y;
    {full, sa, sb, cr, sub, sat, hi, acc, asub} = f;
    if (full) begin
      pa   = sa ? {{32{a[31]}}, a} : {32'd0, a};
      pb   = sb ? {{32{b[31]}}, b} : {32'd0, b};
      prod = pa * pb;
      w    = hi ? prod[63:32] : prod[31:0];
      if (acc) w = asub ? (rd - w) : (w + rd);
      return {1'b0, w};
    end
    sum = 0;
    for (int l = 0; l < 2; l++) begin
      la = (l == 0) ? a[15:0] : a[31:16];
      lb = ((l == 0) != cr) ? b[15:0] : b[31:16];
      x  = sa ? longint'($signed(la)) : longint'(la);
      y  = sb ? longint'($signed(lb)) : longint'(lb);
      p  = x * y;
      if (sub && l == 0) p = -p;
      sum += p;
    end
    if (acc) sum = asub ? (longint'($signed(rd)) - sum) : (sum + longint'($signed(rd)));
    if (sat && sum > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
    if (sat && sum < -64'sd2147483648) return {1'b1, 32'h80000000};
    return {1'b0, sum[31:0]};
  endfunction

  // Present one request, scramble inputs after the accept edge, wait (bounded) for valid_o.
  task automatic issue_op(input logic [8:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rd, output logic [31:0] res, output logic so,
                          output int lat);
    @(negedge clk);
    {full_mode_i, signed_a_i, signed_b_i, crossed_i, sub_i, sat_i, hi_i, accum_i, acc_sub_i} = f;
    op_a_i = a; op_b_i = b; rd_i = rd;
    valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_a_i = $urandom(); op_b_i = $urandom(); rd_i = $urandom();
    hi_i = ~hi_i; sat_i = ~sat_i; sub_i = ~sub_i; crossed_i = ~crossed_i;
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!valid_o) lat = -1;
    res = result_o;
    so  = sat_o;
  endtask

  // Consume the presented result with a one-cycle ready_i pulse.
  task automatic retire();
    @(negedge clk); ready_i = 1'b1;
    @(posedge clk); #1; ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ready_o, valid_o, sat_o, result_o} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset: got rdy=%b vld=%b sat=%b res=%h expected 1 0 0 00000000",
               ready_o, valid_o, sat_o, result_o);
    end
    @(negedge clk); rst_i = 1'b0;
  endtask

  task automatic test_full_mode();
    logic [8:0]  fl [4] = '{9'b111000000, 9'b111000100, 9'b100000100, 9'b100000000};
    logic [31:0] av [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv [4] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    logic [31:0] res; logic so; int lat;
    for (int k = 0; k < 4; k++) begin
      issue_op(fl[k], av[k], bv[k], 32'h0, res, so, lat);
      tests_run++;
      if (res !== ev[k]) begin tests_failed++; $display("FAIL full[%0d] result: got %h expected %h", k, res, ev[k]); end
      tests_run++;
      if (so !== 1'b0) begin tests_failed++; $display("FAIL full[%0d] sat: got %b expected 0", k, so); end
      tests_run++;
      if (lat != 5) begin tests_failed++; $display("FAIL full[%0d] latency: got %0d expected 5", k, lat); end
      retire();
    end
  endtask

  task automatic test_lane_mode();
    logic [8:0]  fl [3] = '{9'b011000000, 9'b011010000, 9'b011100000};
    logic [31:0] ev [3] = '{32'h00000017, 32'h00000007, 32'h00000016};
    logic [31:0] res; logic so; int lat;
    for (int k = 0; k < 3; k++) begin
      issue_op(fl[k], 32'h00030002, 32'h00050004, 32'h0, res, so, lat);
      tests_run++;
      if (res !== ev[k]) begin tests_failed++; $display("FAIL lane[%0d] result: got %h expected %h", k, res, ev[k]); end
      tests_run++;
      if (lat != 3) begin tests_failed++; $display("FAIL lane[%0d] latency: got %0d expected 3", k, lat); end
      retire();
    end
  endtask

  task automatic test_lane_saturation();
    logic [8:0]  fl [2] = '{9'b011001010, 9'b011000010};
    logic [31:0] ev [2] = '{32'h7FFFFFFF, 32'h80000000};
    logic        es [2] = '{1'b1, 1'b0};
    logic [31:0] res; logic so; int lat;
    for (int k = 0; k < 2; k++) begin
      issue_op(fl[k], 32'h80008000, 32'h80008000, 32'h0, res, so, lat);
      tests_run++;
      if (res !== ev[k]) begin tests_failed++; $display("FAIL sat[%0d] result: got %h expected %h", k, res, ev[k]); end
      tests_run++;
      if (so !== es[k]) begin tests_failed++; $display("FAIL sat[%0d] flag: got %b expected %b", k, so, es[k]); end
      tests_run++;
      if (lat != 4) begin tests_failed++; $display("FAIL sat[%0d] latency: got %0d expected 4", k, lat); end
      retire();
    end
  endtask

  task automatic test_full_accumulate();
    logic [8:0]  fl [2] = '{9'b111000010, 9'b111000011};
    logic [31:0] ev [2] = '{32'h00000016, 32'hFFFFFFFE};
    logic [31:0] res; logic so; int lat;
    for (int k = 0; k < 2; k++) begin
      issue_op(fl[k], 32'd3, 32'd4, 32'd10, res, so, lat);
      tests_run++;
      if (res !== ev[k]) begin tests_failed++; $display("FAIL accum[%0d] result: got %h expected %h", k, res, ev[k]); end
      tests_run++;
      if (lat != 6) begin tests_failed++; $display("FAIL accum[%0d] latency: got %0d expected 6", k, lat); end
      retire();
    end
  endtask

  task automatic test_hold();
    logic [8:0] f; logic [31:0] a, b, rd, res; logic [32:0] exp; logic so; int lat; int bad;
    f = 9'b011000000; a = $urandom(); b = $urandom(); rd = $urandom();
    exp = ref_model(f, a, b, rd);
    issue_op(f, a, b, rd, res, so, lat);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!valid_o || ready_o || result_o !== exp[31:0] || sat_o !== exp[32]) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL hold: %0d unstable cycles, last vld=%b rdy=%b res=%h expected vld=1 rdy=0 res=%h",
               bad, valid_o, ready_o, result_o, exp[31:0]);
    end
    retire();
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL hold retire: got rdy=%b vld=%b expected 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic so; int lat; int seen;
    @(negedge clk);
    {full_mode_i, signed_a_i, signed_b_i, crossed_i, sub_i, sat_i, hi_i, accum_i, acc_sub_i} = 9'b111000000;
    op_a_i = $urandom(); op_b_i = $urandom(); valid_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    @(posedge clk); #1; flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush mul: got rdy=%b vld=%b expected 1 0", ready_o, valid_o);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin @(posedge clk); #1; if (valid_o) seen++; end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL flush discard: valid_o high %0d cycles expected 0", seen); end
    @(negedge clk); valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0; flush_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; if (!ready_o || valid_o) seen++; end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL flush idle: request accepted (%0d busy cycles) expected 0", seen); end
    issue_op(9'b011000000, 32'h00030002, 32'h00050004, 32'h0, res, so, lat);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush done: got rdy=%b vld=%b expected 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [8:0] f; logic [31:0] a, b, rd, res; logic [32:0] exp; logic so; int lat; int elat;
    for (int n = 0; n < 60; n++) begin
      f = 9'($urandom()); a = $urandom(); b = $urandom(); rd = $urandom();
      if (n % 4 == 0) begin a = 32'h80008000 | (a & 32'h00FF00FF); b = 32'h80007FFF; end
      exp  = ref_model(f, a, b, rd);
      elat = (f[8] ? 5 : 3) + (f[1] ? 1 : 0);
      issue_op(f, a, b, rd, res, so, lat);
      tests_run++;
      if (res !== exp[31:0] || so !== exp[32]) begin
        tests_failed++;
        $display("FAIL random[%0d] f=%b a=%h b=%h rd=%h: got res=%h sat=%b expected res=%h sat=%b",
                 n, f, a, b, rd, res, so, exp[31:0], exp[32]);
      end
      tests_run++;
      if (lat != elat) begin tests_failed++; $display("FAIL random[%0d] latency: got %0d expected %0d", n, lat, elat); end
      retire();
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    {full_mode_i, signed_a_i, signed_b_i, crossed_i, sub_i, sat_i, hi_i, accum_i, acc_sub_i} = 9'b111000010;
    op_a_i = 32'h12345678; op_b_i = 32'h9ABCDEF0; rd_i = 32'h1; valid_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    @(posedge clk); #1; rst_i = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0;
    tests_run++;
    if ({ready_o, valid_o, sat_o, result_o} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset mid: got rdy=%b vld=%b sat=%b res=%h expected 1 0 0 00000000",
               ready_o, valid_o, sat_o, result_o);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin @(posedge clk); #1; if (valid_o) seen++; end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL reset mid discard: valid_o high %0d cycles expected 0", seen); end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    full_mode_i = 1'b0; signed_a_i = 1'b0; signed_b_i = 1'b0; crossed_i = 1'b0;
    sub_i = 1'b0; sat_i = 1'b0; hi_i = 1'b0; accum_i = 1'b0; acc_sub_i = 1'b0;
    op_a_i = 32'h0; op_b_i = 32'h0; rd_i = 32'h0;
    test_reset();
    test_full_mode();
    test_lane_mode();
    test_lane_saturation();
    test_full_accumulate();
    test_hold();
    test_flush();
    test_random_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
